// File: rtl/wb_master_bridge.sv
// wb_master_bridge: single-outstanding CPU-to-Wishbone classic master with timeout and a recovery cycle
module wb_master_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [31:0] adr_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);
  typedef enum logic [1:0] {IDLE, BUS, RECOVER} state_t;
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic cyc_q, busy_q, done_q, err_q, we_q;
  logic [31:0] adr_q, dat_q, rdata_q;
  logic [3:0] sel_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (req_i) begin
          adr_q   <= addr_i;
          we_q    <= we_i;
          sel_q   <= be_i;
          dat_q   <= wdata_i;
          cnt_q   <= '0;
          cyc_q   <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= BUS;
        end
        BUS: if (ack_i) begin
          cyc_q   <= 1'b0;
          done_q  <= 1'b1;
          if (!we_q) rdata_q <= dat_i;
          state_q <= RECOVER;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cyc_q   <= 1'b0;
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          state_q <= RECOVER;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        RECOVER: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
  assign cyc_o   = cyc_q;
  assign stb_o   = cyc_q;
  assign adr_o   = adr_q;
  assign we_o    = we_q;
  assign sel_o   = sel_q;
  assign dat_o   = dat_q;
endmodule

// File: tb/tb_wb_master_bridge.sv
// tb_wb_master_bridge: directed-vector bench with a registered-ack Wishbone slave model
module tb_wb_master_bridge;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] be = '0;
  logic busy, done, err, cyc, stb, we_o;
  logic [31:0] rdata, adr, dat_o;
  logic [3:0] sel;
  logic slave_en = 1'b1, man_ack = 1'b0, ack_q;
  logic [31:0] slave_rdata = '0;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  // GPIO-style slave: ack is registered and lags one cycle behind cyc deassertion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ack_q <= 1'b0;
    else ack_q <= cyc & stb & slave_en;

  wb_master_bridge #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .busy_o(busy), .done_o(done), .err_o(err),
    .rdata_o(rdata), .cyc_o(cyc), .stb_o(stb), .adr_o(adr), .we_o(we_o),
    .sel_o(sel), .dat_o(dat_o), .dat_i(slave_rdata),
    .ack_i(slave_en ? ack_q : man_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
  endtask

  initial begin
    #2;
    check("rst_cyc", cyc, 0); check("rst_stb", stb, 0); check("rst_we", we_o, 0);
    check("rst_adr", adr, 0); check("rst_sel", sel, 0); check("rst_dat", dat_o, 0);
    check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin tick; check("idle_cyc", cyc, 0); end

    issue(1'b1, 32'h4, 32'hA5, 4'hF);
    tick;
    req = 1'b0;
    check("wr_cyc", cyc, 1); check("wr_stb", stb, 1); check("wr_busy", busy, 1);
    check("wr_adr", adr, 32'h4); check("wr_sel", sel, 4'hF); check("wr_dat", dat_o, 32'hA5);
    check("wr_we", we_o, 1);
    tick;
    check("wr_e1_done", done, 0); check("wr_e1_cyc", cyc, 1);
    tick;
    check("wr_done", done, 1); check("wr_err", err, 0); check("wr_cyc_low", cyc, 0);
    check("wr_rdata_keep", rdata, 0); check("wr_lag_ack", ack_q, 1);
    tick;
    check("wr_no_2nd_done", done, 0); check("wr_busy_low", busy, 0);
    check("wr_adr_hold", adr, 32'h4);

    slave_rdata = 32'h3C;
    issue(1'b0, 32'h0, 32'h0, 4'hF);
    tick;
    check("rd_cyc", cyc, 1); check("rd_adr", adr, 0); check("rd_we", we_o, 0);
    tick;
    check("rd_e1_done", done, 0);
    tick;
    check("rd_done", done, 1); check("rd_err", err, 0); check("rd_rdata", rdata, 32'h3C);
    tick;
    check("rd_e3_cyc", cyc, 0); check("rd_e3_busy", busy, 0); check("rd_e3_done", done, 0);
    slave_rdata = 32'h77;
    tick;
    check("rd_b2b_accept", cyc, 1); check("rd_b2b_busy", busy, 1);
    req = 1'b0;
    tick; tick;
    check("rd2_done", done, 1); check("rd2_rdata", rdata, 32'h77);
    tick;
    check("rd2_idle", busy, 0);

    slave_en = 1'b0;
    slave_rdata = 32'hDEAD_BEEF;
    issue(1'b0, 32'h8, 32'h0, 4'h3);
    tick;
    req = 1'b0;
    check("to_cyc0", cyc, 1);
    for (int i = 1; i < 4; i++) begin
      tick;
      check("to_cyc", cyc, 1); check("to_done_early", done, 0);
    end
    tick;
    check("to_cyc_low", cyc, 0); check("to_done", done, 1); check("to_err", err, 1);
    check("to_rdata_keep", rdata, 32'h77);
    tick;
    check("to_done_clr", done, 0); check("to_err_clr", err, 0);
    tick;
    check("to_busy_low", busy, 0);

    slave_rdata = 32'h5A;
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    tick;
    req = 1'b0;
    for (int i = 1; i < 4; i++) begin tick; check("col_done_early", done, 0); end
    man_ack = 1'b1;
    tick;
    man_ack = 1'b0;
    check("col_done", done, 1); check("col_err", err, 0); check("col_rdata", rdata, 32'h5A);
    tick; tick;
    check("col_idle", busy, 0);

    slave_en = 1'b1;
    issue(1'b1, 32'hC, 32'h1234, 4'h1);
    tick;
    req = 1'b0;
    tick;
    req = 1'b1; addr = 32'h99;
    tick;
    check("bd_done", done, 1);
    tick;
    check("bd_recover_busy", busy, 0);
    req = 1'b0;
    tick;
    check("bd_no_extra", cyc, 0); check("bd_adr_hold", adr, 32'hC);
    tick;
    check("bd_no_extra2", cyc, 0);

    issue(1'b1, 32'h20, 32'h55, 4'hF);
    tick;
    req = 1'b0;
    check("mr_cyc", cyc, 1);
    tick;
    #2 rst_n = 1'b0;
    #1;
    check("mr_cyc_async", cyc, 0); check("mr_stb_async", stb, 0);
    check("mr_busy", busy, 0); check("mr_done", done, 0); check("mr_adr", adr, 0);
    tick;
    check("mr_no_done", done, 0);
    rst_n = 1'b1;
    tick;
    check("mr_idle_cyc", cyc, 0); check("mr_idle_done", done, 0);
    slave_rdata = 32'hA1;
    issue(1'b0, 32'h24, 32'h0, 4'hF);
    tick;
    req = 1'b0;
    check("mr_new_cyc", cyc, 1); check("mr_new_adr", adr, 32'h24);
    tick; tick;
    check("mr_new_done", done, 1); check("mr_new_err", err, 0); check("mr_new_rdata", rdata, 32'hA1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Single-outstanding Wishbone master bridge between the CPU's simple request/done data port and the peripheral Wishbone bus that feeds the GPIO block and other slaves. It registers one CPU request, drives a classic (non-pipelined) Wishbone cycle, and returns read data or a timeout error to the CPU. A recovery cycle follows every transaction, so slaves with a registered, one-cycle-lagging `ack` are never double-acknowledged.

## Interface
- `TIMEOUT`, 255: maximum number of bus cycles to wait for `ack_i` before aborting; valid range 1..(2^CNT_W - 1).
- `CNT_W`, 8: width of the timeout counter.
- `clk_i` in 1: system clock. All logic is on the rising edge.
- `rst_n_i` in 1: asynchronous active-low reset.
- `req_i` in 1: CPU request strobe. It is accepted only when `busy_o` = 0.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: write data.
- `be_i` in 4: byte enables.
- `busy_o` out 1: bridge is occupied; new requests are ignored.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: valid with `done_o`; 1 = timeout.
- `rdata_o` out 32: last successfully acknowledged read data.
- `cyc_o` out 1, `stb_o` out 1: Wishbone cycle and strobe (always equal).
- `adr_o` out 32, `we_o` out 1, `sel_o` out 4, `dat_o` out 32: Wishbone address, write enable, byte select and write data.
- `dat_i` in 32, `ack_i` in 1: Wishbone read data and acknowledge.

## Operation
States:
- **IDLE**
  - `req_i` = 1 at a clock edge: latch `addr_i`, `we_i`, `be_i`, `wdata_i` into `adr_o`/`we_o`/`sel_o`/`dat_o`, clear the counter, assert `cyc_o`/`stb_o`, go to BUS.
- **BUS**
  - `ack_i` = 1 at an edge:
    - Deassert `cyc_o`/`stb_o`.
    - Pulse `done_o`.
    - Drive `err_o` = 0.
    - If the cycle is a read, capture `dat_i` into `rdata_o`.
    - Go to RECOVER.
  - No `ack_i` and counter = `TIMEOUT`-1: deassert `cyc_o`/`stb_o`, pulse `done_o` with `err_o` = 1, leave `rdata_o` unchanged, go to RECOVER.
  - Otherwise increment the counter and stay in BUS.
- **RECOVER**
  - Exactly one cycle.
  - `ack_i` is ignored.
  - Return to IDLE.

Rules:
- `busy_o` = 1 in BUS and RECOVER, 0 in IDLE. This is a registered state decode.
- `req_i` in BUS or RECOVER is dropped, not queued. The requester re-issues it after `busy_o` falls.
- Writes never modify `rdata_o`.
- `adr_o`/`we_o`/`sel_o`/`dat_o` hold their latched values until the next accept, including across IDLE.
- If `ack_i` and the timeout condition occur at the same edge, `ack_i` wins: success, `err_o` = 0.
- `err_o` is 0 whenever `done_o` = 0.

## Timing
- Reset values:
  - `cyc_o` = `stb_o` = `we_o` = 0.
  - `adr_o` = 0, `sel_o` = 0, `dat_o` = 0.
  - `busy_o` = `done_o` = `err_o` = 0, `rdata_o` = 0.
  - State = IDLE, counter = 0.
- Reset asserted mid-transaction: `cyc_o`/`stb_o` drop immediately (asynchronous), with no `done_o`.
- Request accepted at edge E0: `cyc_o`/`stb_o`/`busy_o` are high after E0.
- Slave registers `ack` at E1 and the bridge samples it at E2: `done_o` is high for the cycle after E2, `cyc_o`/`stb_o` are low after E2, and `rdata_o` is valid after E2 and stable until the next acked read.
- RECOVER follows E2; `busy_o` falls after E3; the next request can be accepted at E4.
- Back-to-back throughput: one transaction per 4 cycles with a one-wait-state slave.
- Timeout: `ack_i` is sampled for at most `TIMEOUT` edges after E0. With no `ack_i`, `done_o`/`err_o` are high for the cycle after edge E0+`TIMEOUT`.
- All outputs are registered; there is no combinational path from `ack_i`/`dat_i` to any output.

## Test plan
- **Reset:** assert `rst_n_i` = 0 mid-clock -> all outputs immediately at their reset values. Release and issue no requests -> `cyc_o` remains 0.
- **Write:** write to a GPIO-style registered-ack slave, `addr` 0x4, `wdata` 0x0000_00A5, `be` 0xF -> `adr_o` = 0x4, `sel_o` = 0xF, `dat_o` = 0xA5 while `cyc_o` = 1. `done_o` pulses 2 cycles after accept with `err_o` = 0. `rdata_o` is unchanged. The lagging `ack_i` during RECOVER produces no second `done_o`.
- **Read:** read `addr` 0x0 with the slave returning 0x0000_003C -> `rdata_o` = 0x3C after the `done_o` cycle. `req_i` held high throughout -> the second transaction is accepted exactly 4 cycles after the first.
- **Timeout:** `TIMEOUT` = 4 with a slave that never acks -> `cyc_o` high for exactly 4 cycles, then `done_o` = `err_o` = 1 for one cycle, and `rdata_o` retains its previous value.
- **Ack/timeout collision:** `TIMEOUT` = 4 and `ack_i` arrives exactly at the 4th sampling edge -> `done_o` = 1, `err_o` = 0, data captured.
- **Busy drop and mid-cycle reset:** pulse `req_i` while `busy_o` = 1 -> no extra transaction. Assert reset during BUS -> `cyc_o` = 0 immediately; after release, the bridge is IDLE and accepts a new request normally.
